// File: rtl/kyber_tw_pkg.sv
// Shared constants for the twiddle ROM read path: pass modes, ROM region bases,
// and the per-stage base/shift table also used by the ROM generator script.
package kyber_tw_pkg;

  localparam int ROM_AW           = 7;
  localparam int NUM_PE           = 16;
  localparam int COEF_W           = 12;
  localparam int ROW_W            = NUM_PE * COEF_W;
  localparam int NUM_STAGES       = 7;
  localparam int ISSUES_PER_STAGE = 8;

  localparam logic [ROM_AW-1:0] W_BASE    = 7'd0;
  localparam logic [ROM_AW-1:0] WINV_BASE = 7'd39;
  localparam logic [ROM_AW-1:0] WP_BASE   = 7'd78;

  typedef enum logic [1:0] {
    MODE_NTT  = 2'd0,
    MODE_INTT = 2'd1,
    MODE_PWM  = 2'd2,
    MODE_RSVD = 2'd3
  } tw_mode_e;

  // Early NTT stages reuse one twiddle across 2^shift consecutive issues.
  function automatic logic [ROM_AW-1:0] ntt_base(input int stage);
    logic [ROM_AW-1:0] off;
    case (stage)
      0:       off = 7'd0;
      1:       off = 7'd1;
      2:       off = 7'd3;
      3:       off = 7'd7;
      4:       off = 7'd15;
      5:       off = 7'd23;
      default: off = 7'd31;
    endcase
    return W_BASE + off;
  endfunction

  function automatic logic [1:0] ntt_shift(input int stage);
    case (stage)
      0:       return 2'd3;
      1:       return 2'd2;
      2:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // The inverse transform mirrors the forward one: wide stages first, sharing at the end.
  function automatic logic [ROM_AW-1:0] intt_base(input int stage);
    logic [ROM_AW-1:0] off;
    case (stage)
      0:       off = 7'd0;
      1:       off = 7'd8;
      2:       off = 7'd16;
      3:       off = 7'd24;
      4:       off = 7'd32;
      5:       off = 7'd36;
      default: off = 7'd38;
    endcase
    return WINV_BASE + off;
  endfunction

  function automatic logic [1:0] intt_shift(input int stage);
    case (stage)
      4:       return 2'd1;
      5:       return 2'd2;
      6:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/tw_addr_map.sv
// Combinational (mode, stage, cycle) -> twiddle ROM address map; mirrors the
// table the ROM generator script emits.
module tw_addr_map
  import kyber_tw_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [2:0]        stage,
  input  logic [2:0]        cyc,
  output logic [ROM_AW-1:0] addr
);

  logic [ROM_AW-1:0] ntt_addr  [NUM_STAGES];
  logic [ROM_AW-1:0] intt_addr [NUM_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam logic [ROM_AW-1:0] NTT_B   = ntt_base(gi);
      localparam logic [1:0]        NTT_SH  = ntt_shift(gi);
      localparam logic [ROM_AW-1:0] INTT_B  = intt_base(gi);
      localparam logic [1:0]        INTT_SH = intt_shift(gi);

      logic [2:0] ntt_step;
      logic [2:0] intt_step;

      assign ntt_step      = cyc >> NTT_SH;
      assign intt_step     = cyc >> INTT_SH;
      assign ntt_addr[gi]  = NTT_B + {{(ROM_AW-3){1'b0}}, ntt_step};
      assign intt_addr[gi] = INTT_B + {{(ROM_AW-3){1'b0}}, intt_step};
    end
  endgenerate

  always_comb begin
    addr = '0;
    case (tw_mode_e'(mode))
      MODE_NTT: begin
        if (stage < 3'(NUM_STAGES)) addr = ntt_addr[stage];
      end
      MODE_INTT: begin
        if (stage < 3'(NUM_STAGES)) addr = intt_addr[stage];
      end
      MODE_PWM: addr = WP_BASE + {{(ROM_AW-3){1'b0}}, cyc};
      default:  addr = '0;
    endcase
  end

endmodule

// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM read sequencer for NTT / INTT / PWM passes, with flags aligned to ROM dout.
// Optional inter-stage idle cycles are compiled in with TWGEN_STAGE_GAP_EN.
module twiddle_addr_gen
  import kyber_tw_pkg::*;
#(
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              stall,
  output logic [ROM_AW-1:0] raddr,
  output logic              tw_valid,
  output logic [2:0]        tw_stage,
  output logic              tw_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
`ifdef TWGEN_STAGE_GAP_EN
    , ST_GAP = 2'd3
`endif
  } state_e;

  // With the gap feature absent the length folds to zero so no gap is ever entered.
`ifdef TWGEN_STAGE_GAP_EN
  localparam logic [3:0] GAP_LEN = 4'(STAGE_GAP);
`else
  localparam logic [3:0] GAP_LEN = 4'(STAGE_GAP) & 4'd0;
`endif

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [2:0]        stage_q, stage_d;
  logic [ROM_AW-1:0] raddr_q, raddr_d;
  logic              issue_q, issue_d;
  logic [2:0]        stage_p_q, stage_p_d;
  logic              last_p_q, last_p_d;
  logic              tw_valid_q, tw_valid_d;
  logic [2:0]        tw_stage_q, tw_stage_d;
  logic              tw_last_q, tw_last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
`ifdef TWGEN_STAGE_GAP_EN
  logic [3:0]        gap_cnt_q, gap_cnt_d;
`endif

  logic [ROM_AW-1:0] map_addr;
  logic [2:0]        final_stage;
  logic              issue;
  logic              last_issue;

  tw_addr_map u_map (
    .mode  (mode_q),
    .stage (stage_q),
    .cyc   (cyc_q),
    .addr  (map_addr)
  );

  assign final_stage = (mode_q == MODE_PWM) ? 3'd0 : 3'(NUM_STAGES - 1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cyc_d   = cyc_q;
    stage_d = stage_q;
    raddr_d = raddr_q;
    issue   = 1'b0;
`ifdef TWGEN_STAGE_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          state_d = ST_RUN;
          mode_d  = mode;
          cyc_d   = 3'd0;
          stage_d = 3'd0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          issue   = 1'b1;
          raddr_d = map_addr;
          cyc_d   = cyc_q + 3'd1;
          if (cyc_q == 3'd7) begin
            if (stage_q == final_stage) begin
              state_d = ST_DRAIN;
            end else begin
              stage_d = stage_q + 3'd1;
              if (GAP_LEN != 4'd0) begin
`ifdef TWGEN_STAGE_GAP_EN
                state_d   = ST_GAP;
                gap_cnt_d = GAP_LEN - 4'd1;
`endif
              end
            end
          end
        end
      end
`ifdef TWGEN_STAGE_GAP_EN
      ST_GAP: begin
        if (!stall) begin
          if (gap_cnt_q == 4'd0) state_d = ST_RUN;
          else                   gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
`endif
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    last_issue = issue && (cyc_q == 3'd7) && (stage_q == final_stage);

    // Two flag stages: one matches the raddr register, one the ROM read latency.
    issue_d    = issue;
    stage_p_d  = issue ? stage_q : stage_p_q;
    last_p_d   = last_issue;
    tw_valid_d = issue_q;
    tw_stage_d = stage_p_q;
    tw_last_d  = last_p_q;
    done_d     = last_p_q;
    busy_d     = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_NTT;
      cyc_q      <= 3'd0;
      stage_q    <= 3'd0;
      raddr_q    <= '0;
      issue_q    <= 1'b0;
      stage_p_q  <= 3'd0;
      last_p_q   <= 1'b0;
      tw_valid_q <= 1'b0;
      tw_stage_q <= 3'd0;
      tw_last_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TWGEN_STAGE_GAP_EN
      gap_cnt_q  <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cyc_q      <= cyc_d;
      stage_q    <= stage_d;
      raddr_q    <= raddr_d;
      issue_q    <= issue_d;
      stage_p_q  <= stage_p_d;
      last_p_q   <= last_p_d;
      tw_valid_q <= tw_valid_d;
      tw_stage_q <= tw_stage_d;
      tw_last_q  <= tw_last_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef TWGEN_STAGE_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign raddr    = raddr_q;
  assign tw_valid = tw_valid_q;
  assign tw_stage = tw_stage_q;
  assign tw_last  = tw_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Scoreboard bench for twiddle_addr_gen (default build, no stage gap): a 1-cycle
// identity ROM turns raddr into dout, and a monitor compares each live row.
module tb_twiddle_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       stall = 1'b0;
  logic [6:0] raddr;
  logic       tw_valid;
  logic [2:0] tw_stage;
  logic       tw_last;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  twiddle_addr_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .stall    (stall),
    .raddr    (raddr),
    .tw_valid (tw_valid),
    .tw_stage (tw_stage),
    .tw_last  (tw_last),
    .busy     (busy),
    .done     (done)
  );

  // ROM model: each row holds its own address, read latency one cycle.
  logic [6:0] rom_dout = 7'd0;
  always @(posedge clk) rom_dout <= raddr;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int addr;
    int stage;
    bit is_last;
  } row_t;

  row_t exp_q[$];
  int   exp_done_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   last_addr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int ref_stages(input int m);
    return (m == 2) ? 1 : 7;
  endfunction

  function automatic int ref_addr(input int m, input int s, input int c);
    if (m == 0) begin
      if (s == 0) return 0;
      if (s == 1) return 1 + c / 4;
      if (s == 2) return 3 + c / 2;
      return 7 + 8 * (s - 3) + c;
    end
    if (m == 1) begin
      if (s < 4)  return 39 + 8 * s + c;
      if (s == 4) return 71 + c / 2;
      if (s == 5) return 75 + c / 4;
      return 77;
    end
    return 78 + c;
  endfunction

  task automatic push_pass(input int m);
    row_t r;
    int ns;
    ns = ref_stages(m);
    for (int s = 0; s < ns; s++) begin
      for (int c = 0; c < 8; c++) begin
        r.addr    = ref_addr(m, s, c);
        r.stage   = s;
        r.is_last = (s == ns - 1) && (c == 7);
        exp_q.push_back(r);
        last_addr = r.addr;
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    row_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (tw_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_row: tw_valid=1 with dout=%0d, expected no row (cycle %0d)",
                     rom_dout, cycle);
          end else begin
            e = exp_q.pop_front();
            check("row_addr", int'(rom_dout), e.addr);
            check("row_stage", int'(tw_stage), e.stage);
            check("row_last", int'(tw_last), int'(e.is_last));
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cycle);
          end else begin
            check("done_cycle", cycle, exp_done_q.pop_front());
          end
        end
        if (tw_valid || done) check("done_is_valid_last", int'(done), int'(tw_valid && tw_last));
      end
    end
  end

  // stall_kind: 0 none, 1 random, 2 three cycles before issue index 20.
  task automatic run_pass(input int m, input int stall_kind, input bit mid_start);
    int T, k, n, nrows, nstall, sd;
    bit st;
    push_pass(m);
    start = 1'b1;
    mode  = 2'(m);
    @(negedge clk);
    T = cycle;
    start = 1'b0;
    check("busy_at_accept", int'(busy), 0);
    nrows = ref_stages(m) * 8;
    k = 0; n = 0; nstall = 0; sd = 0;
    while (n < nrows && k < 1000) begin
      st = 1'b0;
      if (stall_kind == 1) st = ($urandom_range(0, 3) == 0);
      if (stall_kind == 2 && n == 20 && sd < 3) begin
        st = 1'b1;
        sd++;
      end
      stall = st;
      if (mid_start) begin
        start = ($urandom_range(0, 5) == 0);
        mode  = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      k++;
      if (st) nstall++;
      else    n++;
      if (k == 1) check("busy_rise", int'(busy), 1);
    end
    start = 1'b0;
    if (k >= 1000) check("issue_budget", n, nrows);
    exp_done_q.push_back(T + k + 1);
    $display("pass mode=%0d accepted_at=%0d stalls=%0d expect_done=%0d", m, T, nstall, T + k + 1);
    stall = 1'($urandom_range(0, 1));
    @(negedge clk);
    stall = 1'b0;
    check("busy_in_drain", int'(busy), 1);
  endtask

  task automatic rsvd_start();
    start = 1'b1;
    mode  = 2'd3;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'd0;
    $display("reserved-mode start issued at cycle %0d", cycle);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsvd_busy", int'(busy), 0);
      check("rsvd_done", int'(done), 0);
      check("idle_raddr_hold", int'(raddr), last_addr);
    end
  endtask

  task automatic reset_mid_pass();
    push_pass(0);
    start = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("reset asserted at NTT issue 30, cycle %0d", cycle);
    check("rst_raddr", int'(raddr), 0);
    check("rst_tw_valid", int'(tw_valid), 0);
    check("rst_tw_stage", int'(tw_stage), 0);
    check("rst_tw_last", int'(tw_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    last_addr = 0;
    check("post_rst_busy", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("init_raddr", int'(raddr), 0);
    check("init_tw_valid", int'(tw_valid), 0);
    check("init_tw_stage", int'(tw_stage), 0);
    check("init_tw_last", int'(tw_last), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(2, 0, 1'b0);
    run_pass(0, 0, 1'b0);
    run_pass(1, 0, 1'b0);
    run_pass(0, 2, 1'b0);
    rsvd_start();
    run_pass(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) run_pass($urandom_range(0, 2), 1, 1'b1);
    reset_mid_pass();
    run_pass(2, 0, 1'b0);

    repeat (4) @(negedge clk);
    check("rows_outstanding", exp_q.size(), 0);
    check("dones_outstanding", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
